square_module: RTL and testbench

- Processing element (PE) for an 8-bit output-stationary systolic array multiplier.
- Each accepted operation takes an A/B operand pair, forwards A to the next PE along the row and B to the next PE along the column, and multiply-accumulates A×B into a local result.
- After N_OPS operations, the PE flags that its result element C is complete.

---
 rtl/square_module.sv | 99 +++++++++
 tb/tb_square_module.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/square_module.sv
// Output-stationary systolic-array PE: forwards A/B operands to its neighbours and
// multiply-accumulates N_OPS unsigned products into a local result element C.
module square_module #(
   parameter int DATA_W = 8,
   parameter int N_OPS  = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] currentAxy_in,
   input  logic [DATA_W-1:0] currentBxy_in,
   input  logic              PERFORM_NEXT_OPERATION,
   output logic [DATA_W-1:0] currentAxy_out,
   output logic [DATA_W-1:0] currentBxy_out,
   output logic              doneMultiplying,
   output logic [DATA_W-1:0] cOutput
);

   localparam int CNT_W  = $clog2(N_OPS + 1);
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = PROD_W + $clog2(N_OPS + 1);

   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, acc_cnt_q, acc_cnt_d;
   logic [PROD_W-1:0] prod_q, prod_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              done_q, done_d;
   logic              accept_s;

   // Next-state logic for the three pipeline stages and the done flag.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      v1_d      = 1'b0;
      cnt_d     = cnt_q;
      prod_d    = PROD_W'(a_q) * PROD_W'(b_q);
      v2_d      = v1_q;
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      done_d    = done_q;

      accept_s = PERFORM_NEXT_OPERATION && (cnt_q < CNT_W'(N_OPS));

      if (accept_s) begin
         a_d   = currentAxy_in;
         b_d   = currentBxy_in;
         v1_d  = 1'b1;
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         a_d   = a_q;
         b_d   = b_q;
      end

      // The N_OPS-th product landing in the accumulator completes C.
      if (v2_q) begin
         acc_d     = acc_q + ACC_W'(prod_q);
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
         if (acc_cnt_q == CNT_W'(N_OPS - 1)) begin
            done_d = 1'b1;
         end else begin
            done_d = done_q;
         end
      end else begin
         acc_d     = acc_q;
         acc_cnt_d = acc_cnt_q;
      end
   end

   // State registers; the async clear also flushes any in-flight products.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         a_q       <= '0;
         b_q       <= '0;
         v1_q      <= 1'b0;
         cnt_q     <= '0;
         prod_q    <= '0;
         v2_q      <= 1'b0;
         acc_q     <= '0;
         acc_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         v1_q      <= v1_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         v2_q      <= v2_d;
         acc_q     <= acc_d;
         acc_cnt_q <= acc_cnt_d;
         done_q    <= done_d;
      end
   end

   assign currentAxy_out  = a_q;
   assign currentBxy_out  = b_q;
   assign cOutput         = acc_q[DATA_W-1:0];
   assign doneMultiplying = done_q;

endmodule

// File: tb/tb_square_module.sv
// Scoreboard bench for square_module: expected forward values and accumulator results
// are queued at each accepted strobe and compared when the DUT should present them.
module tb_square_module;

   logic       CLK;
   logic       RESET;
   logic [7:0] a_in, b_in;
   logic       strobe;
   logic [7:0] a_out, b_out, c_out;
   logic       done;

   square_module #(.DATA_W(8), .N_OPS(3)) dut (
      .CLK                    (CLK),
      .RESET                  (RESET),
      .currentAxy_in          (a_in),
      .currentBxy_in          (b_in),
      .PERFORM_NEXT_OPERATION (strobe),
      .currentAxy_out         (a_out),
      .currentBxy_out         (b_out),
      .doneMultiplying        (done),
      .cOutput                (c_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] fwd_q[$];
   logic [8:0]  res_q[$];

   int         m_cnt, m_acc;
   logic [7:0] m_last_a, m_last_b, m_last_c;
   logic       m_last_done;
   logic       h0, h1, h2;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      fwd_q.delete();
      res_q.delete();
      m_cnt = 0; m_acc = 0;
      m_last_a = 8'd0; m_last_b = 8'd0; m_last_c = 8'd0; m_last_done = 1'b0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
   endtask

   // Hold reset with busy inputs; outputs must clear asynchronously and stay clear.
   task automatic do_reset();
      a_in = 8'd77; b_in = 8'd99; strobe = 1'b1;
      RESET = 1'b0;
      #1;
      check_val("rst_async_c", {24'd0, c_out}, 32'd0);
      check_val("rst_async_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_val("rst_hold_a", {24'd0, a_out}, 32'd0);
      check_val("rst_hold_b", {24'd0, b_out}, 32'd0);
      check_val("rst_hold_c", {24'd0, c_out}, 32'd0);
      check_val("rst_hold_done", {31'd0, done}, 32'd0);
      model_clear();
      strobe = 1'b0; a_in = 8'd0; b_in = 8'd0;
      RESET = 1'b1;
   endtask

   task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b);
      logic        acc_now;
      logic [15:0] f;
      logic [8:0]  r;
      strobe = s; a_in = a; b_in = b;
      @(posedge CLK);
      acc_now = s && (m_cnt < 3);
      if (acc_now) begin
         fwd_q.push_back({a, b});
         m_cnt++;
         m_acc = m_acc + int'(a) * int'(b);
         r = {(m_cnt == 3) ? 1'b1 : 1'b0, m_acc[7:0]};
         res_q.push_back(r);
      end
      h2 = h1; h1 = h0; h0 = acc_now;
      @(negedge CLK);
      if (acc_now) begin
         f = fwd_q.pop_front();
         m_last_a = f[15:8]; m_last_b = f[7:0];
      end
      check_val("fwd_a", {24'd0, a_out}, {24'd0, m_last_a});
      check_val("fwd_b", {24'd0, b_out}, {24'd0, m_last_b});
      if (h2) begin
         r = res_q.pop_front();
         m_last_c = r[7:0]; m_last_done = r[8];
      end
      check_val("c_out", {24'd0, c_out}, {24'd0, m_last_c});
      check_val("done", {31'd0, done}, {31'd0, m_last_done});
   endtask

   initial begin
      RESET = 1'b1; strobe = 1'b0; a_in = 8'd0; b_in = 8'd0;
      model_clear();
      @(negedge CLK);

      // Consecutive dot product followed by an overrun strobe.
      do_reset();
      step(1'b1, 8'd1, 8'd10);
      step(1'b1, 8'd2, 8'd13);
      step(1'b1, 8'd3, 8'd16);
      step(1'b1, 8'd3, 8'd16);
      step(1'b1, 8'd9, 8'd9);
      repeat (3) step(1'b0, 8'd0, 8'd0);
      check_val("dot_final", {24'd0, c_out}, 32'd84);
      check_val("dot_done", {31'd0, done}, 32'd1);

      // Gapped strobes.
      do_reset();
      step(1'b1, 8'd1, 8'd10);
      repeat (2) step(1'b0, 8'd5, 8'd5);
      step(1'b1, 8'd2, 8'd13);
      repeat (2) step(1'b0, 8'd5, 8'd5);
      step(1'b1, 8'd3, 8'd16);
      repeat (4) step(1'b0, 8'd0, 8'd0);
      check_val("gap_final", {24'd0, c_out}, 32'd84);

      // Accumulator wraps modulo 256.
      do_reset();
      repeat (3) step(1'b1, 8'd255, 8'd255);
      repeat (3) step(1'b0, 8'd0, 8'd0);
      check_val("wrap_final", {24'd0, c_out}, 32'd3);
      check_val("wrap_done", {31'd0, done}, 32'd1);

      // Reset mid-run must leave no residue.
      do_reset();
      step(1'b1, 8'd200, 8'd7);
      step(1'b1, 8'd100, 8'd3);
      do_reset();
      step(1'b1, 8'd1, 8'd10);
      step(1'b1, 8'd2, 8'd13);
      step(1'b1, 8'd3, 8'd16);
      repeat (3) step(1'b0, 8'd0, 8'd0);
      check_val("midrst_final", {24'd0, c_out}, 32'd84);

      // Random operands and strobe patterns.
      for (int run = 0; run < 4; run++) begin
         do_reset();
         for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         end
         repeat (3) step(1'b0, 8'd0, 8'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
